// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared state encoding and stage-boundary widths for the pipeline registers
package cpu_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   localparam int IF_ID_W  = 96;
   localparam int ID_EX_W  = 160;
   localparam int EX_MEM_W = 112;
   localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional two-entry skid buffer and flush
module pipe_stage_reg #(
   parameter int               WIDTH       = 96,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               SKID        = 1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InData,
   input  logic             Flush,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData,
   output logic [1:0]       Occupancy
);
   // Explicit imports: the SKID state literal would collide with the SKID parameter.
   import cpu_pipe_pkg::pipe_state_t;
   import cpu_pipe_pkg::EMPTY;
   import cpu_pipe_pkg::FULL;

   if (SKID != 0) begin : g_skid
      pipe_state_t      st_q, st_nx;
      logic [WIDTH-1:0] m_q, s_q;
      logic             ir_q;
      logic             accept, drain;

      assign accept = InValid & ir_q;
      assign drain  = (st_q != EMPTY) & OutReady;

      always_comb begin
         st_nx = st_q;
         case (st_q)
            EMPTY:   if (accept) st_nx = FULL;
            FULL: begin
               if (accept && !drain)      st_nx = cpu_pipe_pkg::SKID;
               else if (!accept && drain) st_nx = EMPTY;
            end
            default: if (drain) st_nx = FULL;
         endcase
         if (Flush) st_nx = EMPTY;
      end

      // InReady is a flop so the upstream stage never sees a combinational path from OutReady.
      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            st_q <= EMPTY;
            m_q  <= RESET_VALUE;
            s_q  <= RESET_VALUE;
            ir_q <= 1'b0;
         end else begin
            st_q <= st_nx;
            ir_q <= (st_nx != cpu_pipe_pkg::SKID);
            if (Flush) begin
               m_q <= RESET_VALUE;
               s_q <= RESET_VALUE;
            end else begin
               case (st_q)
                  EMPTY: if (accept) m_q <= InData;
                  FULL: begin
                     if (accept && drain) m_q <= InData;
                     else if (accept)     s_q <= InData;
                  end
                  default: if (drain) m_q <= s_q;
               endcase
            end
         end
      end

      assign InReady   = ir_q;
      assign OutValid  = (st_q != EMPTY);
      assign OutData   = m_q;
      assign Occupancy = st_q;
   end else begin : g_single
      logic             v_q;
      logic [WIDTH-1:0] m_q;
      logic             ready;

      assign ready = Rst_n & (~v_q | OutReady);

      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            v_q <= 1'b0;
            m_q <= RESET_VALUE;
         end else if (Flush) begin
            v_q <= 1'b0;
            m_q <= RESET_VALUE;
         end else if (InValid && ready) begin
            v_q <= 1'b1;
            m_q <= InData;
         end else if (v_q && OutReady) begin
            v_q <= 1'b0;
         end
      end

      assign InReady   = ready;
      assign OutValid  = v_q;
      assign OutData   = m_q;
      assign Occupancy = {1'b0, v_q};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid and single-register builds
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [95:0] in_data;

   logic        a_ir, a_ov;
   logic [95:0] a_od;
   logic [1:0]  a_occ;
   logic        b_ir, b_ov;
   logic [7:0]  b_od;
   logic [1:0]  b_occ;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(96), .RESET_VALUE(96'h0), .SKID(1)) u_skid (
      .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(a_ir), .InData(in_data),
      .Flush(flush), .OutValid(a_ov), .OutReady(out_ready), .OutData(a_od), .Occupancy(a_occ)
   );

   pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'h0), .SKID(0)) u_single (
      .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(b_ir), .InData(in_data[7:0]),
      .Flush(flush), .OutValid(b_ov), .OutReady(out_ready), .OutData(b_od), .Occupancy(b_occ)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [95:0] sbq [2][$];
   bit          win [2];
   bit          stall [2];
   bit          zexp [2];
   logic [95:0] stall_d [2];

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One scoreboard step per cycle, sampled just before the rising edge.
   task automatic mon(input int k, input bit skid, input logic ir, input logic ov,
                      input logic [95:0] od, input logic [1:0] occ, input logic [95:0] mask);
      logic [95:0] e;
      logic        exp_ir;
      string       p;
      p = $sformatf("d%0d_", k);
      if (!rst_n) begin
         sbq[k].delete();
         win[k]   = 1'b1;
         stall[k] = 1'b0;
         zexp[k]  = 1'b0;
         chk({p, "rst_ov"}, ov, 0);
         chk({p, "rst_occ"}, occ, 0);
         chk({p, "rst_data"}, od, 0);
         chk({p, "rst_ir"}, ir, 0);
         return;
      end
      if (skid) exp_ir = win[k] ? 1'b0 : (sbq[k].size() != 2);
      else      exp_ir = (sbq[k].size() == 0) || out_ready;
      win[k] = 1'b0;
      chk({p, "in_ready"}, ir, exp_ir);
      chk({p, "out_valid"}, ov, sbq[k].size() != 0);
      chk({p, "occupancy"}, occ, 96'(sbq[k].size()));
      if (zexp[k]) begin
         chk({p, "flush_data"}, od, 0);
         zexp[k] = 1'b0;
      end
      if (stall[k]) chk({p, "stable"}, od, stall_d[k]);
      if (ov && out_ready) begin
         if (sbq[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %sunexpected: got %h want none at %0t", p, od, $time);
         end else begin
            e = sbq[k].pop_front();
            chk({p, "data"}, od, e);
         end
      end
      stall[k]   = ov && !out_ready && !flush;
      stall_d[k] = od;
      if (flush) begin
         sbq[k].delete();
         zexp[k] = 1'b1;
      end else if (in_valid && ir) begin
         sbq[k].push_back(in_data & mask);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         mon(0, 1'b1, a_ir, a_ov, a_od, a_occ, {96{1'b1}});
         mon(1, 1'b0, b_ir, b_ov, {88'h0, b_od}, b_occ, 96'hff);
      end
   end

   task automatic cyc(input logic iv, input logic [95:0] d, input logic orr, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = orr;
      flush     = fl;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t1_ir_after_release", a_ir, 1);

      // streaming
      cyc(1, 'h11, 1, 0); cyc(1, 'h22, 1, 0); cyc(1, 'h33, 1, 0);
      cyc(0, 0, 1, 0);    cyc(0, 0, 1, 0);

      // backpressure into the skid entry
      cyc(1, 'hA, 0, 0); cyc(1, 'hB, 0, 0); cyc(0, 0, 0, 0);
      #1;
      chk("t3_occ2", a_occ, 2);
      chk("t3_ir0", a_ir, 0);
      chk("t3_held", a_od, 'hA);
      cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
      #1;
      chk("t3_occ0", a_occ, 0);
      chk("t3_ir1", a_ir, 1);

      // flush beats a simultaneous offer
      cyc(1, 'hA, 0, 0); cyc(1, 'hB, 0, 0); cyc(1, 'hC, 0, 1);
      cyc(0, 0, 1, 0);
      #1;
      chk("t4_ov", a_ov, 0);
      chk("t4_data", a_od, 0);
      chk("t4_ir", a_ir, 1);
      cyc(0, 0, 1, 0);

      // single-register build: ready follows OutReady within the cycle
      cyc(1, 'h5, 0, 0); cyc(1, 'h6, 0, 0);
      #1;
      chk("t5_ir_blocked", b_ir, 0);
      cyc(1, 'h7, 1, 0);
      #1;
      chk("t5_ir_comb", b_ir, 1);
      cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);

      // asynchronous reset in the middle of a transfer
      cyc(1, 'h8, 0, 0); cyc(1, 'h9, 0, 0);
      @(posedge clk); #2;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("t1_async_ov", a_ov, 0);
      chk("t1_async_occ", a_occ, 0);
      chk("t1_async_data", a_od, 0);
      chk("t1_async_b_ov", b_ov, 0);
      chk("t1_async_b_data", b_od, 0);
      cyc(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
         if (i == 5000) begin
            @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      end
      repeat (4) cyc(0, 0, 1, 0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
